// File: rtl/alu_sequencer.sv
// Issues single-cycle operations to an external combinational ALU and runs
// iterative 32-step signed multiply/divide locally, collecting results in Z (HI/LO).
module alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_start,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_ready,
    output logic             out_done,
    output logic             out_div_zero,
    output logic [WIDTH-1:0] out_alu_a,
    output logic [WIDTH-1:0] out_alu_b,
    output logic [3:0]       out_alu_opcode,
    input  logic [WIDTH-1:0] in_alu_result,
    output logic [WIDTH-1:0] out_zhi,
    output logic [WIDTH-1:0] out_zlo
);

    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_NEG = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1011;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, MUL, DIV, FIX, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] dividend;
    logic             sign_q;
    logic             sign_r;
    logic             is_div;
    logic             div0_pend;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] signed_product;
    logic [WIDTH-1:0]   quotient_fix;
    logic [WIDTH-1:0]   remainder_fix;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    assign out_ready = (state == IDLE) || (state == DONE);
    assign out_done  = (state == DONE);
    assign accept    = in_start && out_ready;

    // MUL keeps the product as {hi,lo} with the multiplier shifting out of lo;
    // DIV keeps the partial remainder in hi and shifts quotient bits into lo.
    assign mul_sum        = {1'b0, hi} + (lo[0] ? {1'b0, mag_a} : '0);
    assign div_shift      = {hi, lo[WIDTH-1]};
    assign div_trial      = div_shift - {1'b0, mag_b};
    assign product        = {hi, lo};
    assign signed_product = sign_q ? -product : product;
    assign quotient_fix   = sign_q ? -lo : lo;
    assign remainder_fix  = sign_r ? -hi : hi;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) state <= IDLE;
        else           state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    if (in_opcode == OP_MUL)                    next_state = MUL;
                    else if (in_opcode == OP_DIV && in_b != '0) next_state = DIV;
                    else                                        next_state = ISSUE;
                end else if (state == DONE) begin
                    next_state = IDLE;
                end
            end
            ISSUE:    next_state = DONE;
            MUL, DIV: if (cnt == LAST) next_state = FIX;
            FIX:      next_state = DONE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            cnt            <= '0;
            hi             <= '0;
            lo             <= '0;
            mag_a          <= '0;
            mag_b          <= '0;
            dividend       <= '0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            is_div         <= 1'b0;
            div0_pend      <= 1'b0;
            out_alu_a      <= '0;
            out_alu_b      <= '0;
            out_alu_opcode <= '0;
            out_zhi        <= '0;
            out_zlo        <= '0;
            out_div_zero   <= 1'b0;
        end else if (accept) begin
            cnt          <= '0;
            hi           <= '0;
            lo           <= (in_opcode == OP_DIV) ? magnitude(in_a) : magnitude(in_b);
            mag_a        <= magnitude(in_a);
            mag_b        <= magnitude(in_b);
            dividend     <= in_a;
            sign_q       <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
            sign_r       <= in_a[WIDTH-1];
            is_div       <= (in_opcode == OP_DIV);
            div0_pend    <= (in_opcode == OP_DIV) && (in_b == '0);
            out_div_zero <= 1'b0;
            // ALU ports only move for ops the ALU actually executes.
            if (in_opcode != OP_MUL && in_opcode != OP_DIV) begin
                out_alu_a      <= in_a;
                out_alu_b      <= (in_opcode == OP_NEG || in_opcode == OP_NOT) ? '0 : in_b;
                out_alu_opcode <= in_opcode;
            end
        end else begin
            case (state)
                ISSUE: begin
                    if (div0_pend) begin
                        out_zlo      <= '1;
                        out_zhi      <= dividend;
                        out_div_zero <= 1'b1;
                    end else begin
                        out_zlo <= in_alu_result;
                        out_zhi <= '0;
                    end
                end
                MUL: begin
                    hi  <= mul_sum[WIDTH:1];
                    lo  <= {mul_sum[0], lo[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                end
                DIV: begin
                    hi  <= div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
                    lo  <= {lo[WIDTH-2:0], ~div_trial[WIDTH]};
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    if (is_div) begin
                        out_zlo <= quotient_fix;
                        out_zhi <= remainder_fix;
                    end else begin
                        out_zhi <= signed_product[2*WIDTH-1:WIDTH];
                        out_zlo <= signed_product[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer: a transaction-level model
// built on signed 64-bit arithmetic is compared with the DUT on every cycle.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  opcode = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ready;
    logic        done;
    logic        div_zero;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic [31:0] zhi;
    logic [31:0] zlo;

    int compared = 0;
    int mismatched = 0;
    bit checking = 1'b0;

    // Transaction-level model state: 0 idle, 1 busy, 2 result visible.
    int          m_phase = 0;
    int          m_left = 0;
    logic [31:0] m_zhi = '0;
    logic [31:0] m_zlo = '0;
    logic        m_dz = 1'b0;
    logic [31:0] p_zhi = '0;
    logic [31:0] p_zlo = '0;
    logic        p_dz = 1'b0;
    logic [31:0] m_pa = '0;
    logic [31:0] m_pb = '0;
    logic [3:0]  m_pop = '0;
    bit          m_ports_known = 1'b1;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(32)) dut (
        .in_clk         (clk),
        .in_rst_n       (rst_n),
        .in_start       (start),
        .in_opcode      (opcode),
        .in_a           (a),
        .in_b           (b),
        .out_ready      (ready),
        .out_done       (done),
        .out_div_zero   (div_zero),
        .out_alu_a      (alu_a),
        .out_alu_b      (alu_b),
        .out_alu_opcode (alu_op),
        .in_alu_result  (alu_result),
        .out_zhi        (zhi),
        .out_zlo        (zlo)
    );

    function automatic logic [31:0] alu_fn(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
        int s;
        s = int'(y[4:0]);
        case (op)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x << s;
            4'd3:    return x >> s;
            4'd4:    return (x << s) | (x >> (32 - s));
            4'd5:    return (x >> s) | (x << (32 - s));
            4'd6:    return x & y;
            4'd7:    return x | y;
            4'd10:   return y - x;
            4'd11:   return ~x ^ y;
            default: return x ^ {y[15:0], y[31:16]} ^ {28'h0, op};
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_op);

    function automatic logic [31:0] eff_b(input logic [3:0] op, input logic [31:0] y);
        return (op == 4'd10 || op == 4'd11) ? 32'h0 : y;
    endfunction

    function automatic void model_op(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op,
                                     output logic [31:0] ohi, output logic [31:0] olo,
                                     output logic odz, output int lat);
        longint sx, sy, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        odz = 1'b0;
        lat = 2;
        if (op == 4'd8) begin
            r = sx * sy;
            ohi = r[63:32];
            olo = r[31:0];
            lat = 34;
        end else if (op == 4'd9 && y != 0) begin
            r = sx / sy;
            olo = r[31:0];
            r = sx % sy;
            ohi = r[31:0];
            lat = 34;
        end else if (op == 4'd9) begin
            olo = 32'hFFFF_FFFF;
            ohi = x;
            odz = 1'b1;
        end else begin
            olo = alu_fn(x, eff_b(op, y), op);
            ohi = 32'h0;
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advances one transaction step per clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_left = 0; m_zhi = '0; m_zlo = '0; m_dz = 1'b0;
            m_pa = '0; m_pb = '0; m_pop = '0; m_ports_known = 1'b1;
        end else begin
            int lat;
            if (m_phase == 1) begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = 2; m_zhi = p_zhi; m_zlo = p_zlo; m_dz = p_dz;
                end
            end else if (start) begin
                model_op(a, b, opcode, p_zhi, p_zlo, p_dz, lat);
                m_dz = 1'b0;
                m_phase = 1;
                m_left = lat - 1;
                if (opcode == 4'd9 && b == 0) begin
                    m_ports_known = 1'b0;
                end else if (opcode != 4'd8 && opcode != 4'd9) begin
                    m_pa = a; m_pb = eff_b(opcode, b); m_pop = opcode; m_ports_known = 1'b1;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (checking) begin
            check("ready", ready, m_phase != 1);
            check("done", done, m_phase == 2);
            check("zhi", zhi, m_zhi);
            check("zlo", zlo, m_zlo);
            check("div_zero", div_zero, m_dz);
            if (m_ports_known) begin
                check("alu_a", alu_a, m_pa);
                check("alu_b", alu_b, m_pb);
                check("alu_op", alu_op, m_pop);
            end
        end
    end

    task automatic apply_stimulus(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
        a = x; b = y; opcode = op; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic [31:0] x, input logic [31:0] y, input logic [3:0] op,
                                input logic [31:0] ezhi, input logic [31:0] ezlo, input logic edz,
                                input int elat, input bit chk_ports, input int inject_at, input int rst_at);
        int k;
        k = 0;
        apply_stimulus(x, y, op);
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (k == 1) check({tag, "_dz_clear"}, div_zero, 1'b0);
            if (chk_ports && k == 1) begin
                check({tag, "_port_a"}, alu_a, x);
                check({tag, "_port_b"}, alu_b, eff_b(op, y));
                check({tag, "_port_op"}, alu_op, op);
            end
            if (inject_at > 0 && k == inject_at - 1) begin
                start = 1'b1; opcode = 4'd6; a = $urandom; b = $urandom;
            end
            if (inject_at > 0 && k == inject_at) start = 1'b0;
            if (rst_at > 0 && k == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check({tag, "_rst_ready"}, ready, 1'b1);
                check({tag, "_rst_done"}, done, 1'b0);
                check({tag, "_rst_dz"}, div_zero, 1'b0);
                check({tag, "_rst_zhi"}, zhi, 32'h0);
                check({tag, "_rst_zlo"}, zlo, 32'h0);
                check({tag, "_rst_alu_a"}, alu_a, 32'h0);
                check({tag, "_rst_alu_b"}, alu_b, 32'h0);
                check({tag, "_rst_alu_op"}, alu_op, 4'h0);
                return;
            end
            if (done) break;
        end
        check({tag, "_latency"}, k, elat);
        check({tag, "_zhi"}, zhi, ezhi);
        check({tag, "_zlo"}, zlo, ezlo);
        check({tag, "_dz"}, div_zero, edz);
    endtask

    initial begin
        logic [31:0] corners [5];
        corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'h8000_0000;
        corners[3] = 32'hFFFF_FFFF; corners[4] = 32'h7FFF_FFFF;

        $display("[TB] start");
        repeat (3) @(negedge clk);
        checking = 1'b1;
        #2 rst_n = 1'b1;
        #1;
        check("reset_ready", ready, 1'b1);
        check("reset_zlo", zlo, 32'h0);
        check("reset_alu_op", alu_op, 4'h0);
        @(negedge clk);

        check_output("add", 32'd5, 32'd7, 4'd0, 32'h0, 32'd12, 1'b0, 2, 1'b1, 0, 0);
        @(negedge clk);
        check_output("mul_neg", 32'hFFFF_FFFD, 32'd7, 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 1'b0, 10, 0);
        @(negedge clk);
        check("done_once", done, 1'b0);
        check_output("mul_min", 32'h8000_0000, 32'h8000_0000, 4'd8, 32'h4000_0000, 32'h0, 1'b0, 34, 1'b0, 0, 0);
        @(negedge clk);
        check_output("div_neg", 32'hFFFF_FFF9, 32'd2, 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 1'b0, 0, 0);
        @(negedge clk);
        check_output("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 4'd9, 32'h0, 32'h8000_0000, 1'b0, 34, 1'b0, 0, 0);
        @(negedge clk);
        check_output("div_zero", 32'd100, 32'd0, 4'd9, 32'h64, 32'hFFFF_FFFF, 1'b1, 2, 1'b0, 0, 0);
        check_output("b2b_add", 32'd1, 32'd2, 4'd0, 32'h0, 32'd3, 1'b0, 2, 1'b1, 0, 0);
        @(negedge clk);
        check_output("neg_op", 32'd9, 32'd77, 4'd10, 32'h0, 32'hFFFF_FFF7, 1'b0, 2, 1'b1, 0, 0);
        @(negedge clk);
        check_output("div_rst", 32'd1000, 32'd7, 4'd9, 32'h0, 32'h0, 1'b0, 34, 1'b0, 0, 20);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_output("add_after_rst", 32'd9, 32'd4, 4'd0, 32'h0, 32'd13, 1'b0, 2, 1'b1, 0, 0);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] x, y, ehi, elo;
            logic [3:0]  op;
            logic        edz;
            int          lat, sel, inj;
            sel = int'($urandom_range(0, 9));
            if (sel < 3)      op = 4'd8;
            else if (sel < 6) op = 4'd9;
            else              op = 4'($urandom_range(0, 15));
            x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            model_op(x, y, op, ehi, elo, edz, lat);
            inj = (lat == 34 && $urandom_range(0, 1) == 1) ? int'($urandom_range(2, 30)) : 0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            check_output("rand", x, y, op, ehi, elo, edz, lat, 1'b0, inj, 0);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Sequencer that issues operations to the combinational 32-bit ALU and collects their results into the Z register pair, out_zhi and out_zlo.
- Single-cycle ALU ops (add, sub, shifts, rotates, and, or, neg, not) are driven onto the ALU ports for one cycle; the result is captured into out_zlo.
- The ALU does not compute mul (1000) or div (1001); this block executes them itself as iterative 32-step signed multiply and divide, producing a 64-bit result in HI/LO.
- Sits between the control unit (start/done handshake) and the ALU.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
in_clk  input  1  rising-edge clock
in_rst_n  input  1  asynchronous active-low reset
in_start  input  1  request strobe; accepted when in_start && out_ready at a rising edge
in_opcode  input  4  ALU opcode, using the ALU's opcode encoding
in_a  input  WIDTH  operand A (multiplicand / dividend)
in_b  input  WIDTH  operand B (multiplier / divisor)
out_ready  output  1  high in IDLE and DONE
out_done  output  1  one-cycle pulse; Z outputs are valid while it is high and hold until the next acceptance
out_div_zero  output  1  set by a div whose divisor is 0; cleared on the next acceptance
out_alu_a  output  WIDTH  operand A to the ALU
out_alu_b  output  WIDTH  operand B to the ALU
out_alu_opcode  output  4  opcode to the ALU
in_alu_result  input  WIDTH  combinational result from the ALU
out_zhi  output  WIDTH  Z high word
out_zlo  output  WIDTH  Z low word

Behaviour:
- Reset (asynchronous, any state, including mid-iteration):
  - state=IDLE; iteration counter=0.
  - out_zhi=0, out_zlo=0, out_done=0, out_div_zero=0.
  - out_alu_a=0, out_alu_b=0, out_alu_opcode=0.
  - out_ready=1 once reset is released.
- Acceptance: operands and opcode are registered at the acceptance edge. in_start is ignored in ISSUE, MUL, DIV and FIX; there is no queuing.
- States: IDLE, ISSUE, MUL, DIV, FIX, DONE.
- IDLE / DONE on acceptance:
  - opcode 1000 -> MUL.
  - opcode 1001 with b!=0 -> DIV.
  - opcode 1001 with b==0 -> ISSUE (divide-by-zero path).
  - any other opcode -> ISSUE.
- DONE with no acceptance -> IDLE after one cycle.
- ISSUE (one cycle):
  - Drive the registered a, b and opcode onto the ALU ports; for opcodes 1010/1011 drive out_alu_b=0.
  - At the end of the cycle: out_zlo<=in_alu_result, out_zhi<=0, then -> DONE.
  - Unused opcodes 1100-1111 are passed through unchanged; whatever the ALU returns is captured.
  - Divide-by-zero path (ALU port values are don't-care):
    - out_zlo<=all ones, out_zhi<=dividend, out_div_zero<=1, then -> DONE.
- ALU ports outside ISSUE hold their last values.
- MUL:
  - At entry, take magnitudes |a| and |b| as unsigned WIDTH-bit values; 0x80000000 has magnitude 2^31.
  - Record the result sign as a[31]^b[31].
  - Shift-add one multiplier bit per cycle for WIDTH cycles into a 2*WIDTH product, then -> FIX.
- DIV:
  - Take magnitudes as in MUL; quotient sign is a[31]^b[31], remainder sign is a[31].
  - Restoring division, one quotient bit per cycle for WIDTH cycles, then -> FIX.
- FIX (one cycle):
  - Apply signs with two's-complement negation.
  - mul: {out_zhi,out_zlo} = signed 64-bit product.
  - div: out_zlo=quotient, out_zhi=remainder; the quotient truncates toward zero.
  - Overflow: 0x80000000 / 0xFFFFFFFF gives out_zlo=0x80000000, out_zhi=0 (truncated, no flag).
  - -> DONE.
- Latency, counted in rising edges after the acceptance edge at which out_done first reads high:
  - single-cycle ops and div-by-zero: 2.
  - mul and div: WIDTH+2 (34 for the default).
- Back-to-back: acceptance in DONE is allowed. out_done stays high that cycle; the next state follows the new opcode.
- out_zhi and out_zlo change only at ISSUE or FIX completion, or at reset.

Test Plan:
- add, a=5, b=7, opcode 0000 -> ALU ports show 5/7/0000 during ISSUE; 2 edges later out_done=1, out_zlo=12, out_zhi=0.
- mul, a=0xFFFFFFFD (-3), b=7 -> out_done at edge 34; out_zhi=0xFFFFFFFF, out_zlo=0xFFFFFFEB; also a=b=0x80000000 -> out_zhi=0x40000000, out_zlo=0.
- div, a=0xFFFFFFF9 (-7), b=2 -> out_done at edge 34; out_zlo=0xFFFFFFFD, out_zhi=0xFFFFFFFF. Separately, a=0x80000000, b=0xFFFFFFFF -> out_zlo=0x80000000, out_zhi=0.
- div, a=100, b=0 -> out_done at edge 2; out_div_zero=1, out_zlo=0xFFFFFFFF, out_zhi=0x64. The next accepted add clears out_div_zero.
- Pulse in_start with an and op at edge 10 of a running mul -> ignored; the mul result is unchanged and out_done fires once, at edge 34.
- Assert in_rst_n=0 at edge 20 of a div -> immediately state=IDLE, all outputs 0, out_ready=1. A fresh add then completes normally.
